// File: rtl/led_scroll_ctrl.sv
// Avalon-MM write master that scrolls a segment-byte message across the
// eight emulated digits of the VGA LED display and arbitrates host writes.
module led_scroll_ctrl #(
  parameter int unsigned MSG_DEPTH = 32,
  parameter int unsigned TICK_DIV  = 5_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         load_valid,
  input  logic [$clog2(MSG_DEPTH)-1:0] load_index,
  input  logic [7:0]                   load_data,
  input  logic                         len_wr,
  input  logic [$clog2(MSG_DEPTH):0]   len_in,
  input  logic                         host_req,
  input  logic [1:0]                   host_addr,
  input  logic [15:0]                  host_data,
  output logic                         host_gnt,
  output logic                         av_chipselect,
  output logic                         av_write,
  output logic [1:0]                   av_address,
  output logic [15:0]                  av_writedata,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int unsigned AW = $clog2(MSG_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, FRAME, HOST} state_t;

  state_t        state;
  logic [1:0]    beat;
  logic [7:0]    msg [MSG_DEPTH];
  logic [AW-1:0] offset;
  logic [AW-1:0] ptr;
  logic [LW-1:0] len;
  logic [LW-1:0] flen;
  logic          pending;
  logic [TW-1:0] tick_cnt;

  // (p + 1) mod n, for p < n
  function automatic logic [AW-1:0] inc1(input logic [AW-1:0] p, input logic [LW-1:0] n);
    logic [LW-1:0] s;
    s = {1'b0, p} + LW'(1);
    return (s >= n) ? '0 : s[AW-1:0];
  endfunction

  // (p + 2) mod n, for p < n; n = 1 wraps twice
  function automatic logic [AW-1:0] inc2(input logic [AW-1:0] p, input logic [LW-1:0] n);
    logic [LW-1:0] s;
    s = {1'b0, p} + LW'(2);
    if (n <= LW'(1)) return '0;
    else if (s >= n) return AW'(s - n);
    else return s[AW-1:0];
  endfunction

  logic          tick_c;
  logic          frame_ok_c;
  logic          decide_c;
  state_t        pick_c;
  logic          start_c;
  logic [AW-1:0] rd_base_c;
  logic [LW-1:0] rd_len_c;
  logic [AW-1:0] rd_pair_c;
  logic [AW-1:0] ptr_nxt_c;
  logic [15:0]   beat_data_c;
  logic [LW-1:0] len_sat_c;

  // Arbitration and frame read-pointer selection
  always_comb begin
    tick_c      = (tick_cnt == TW'(TICK_DIV - 1));
    frame_ok_c  = pending && (len != '0);
    decide_c    = (state == IDLE) || (state == HOST) || ((state == FRAME) && (beat == 2'd3));
    pick_c      = IDLE;
    if (state == HOST) begin
      if (frame_ok_c)    pick_c = FRAME;
      else if (host_req) pick_c = HOST;
    end else begin
      if (host_req)        pick_c = HOST;
      else if (frame_ok_c) pick_c = FRAME;
    end
    start_c     = decide_c && (pick_c == FRAME);
    rd_base_c   = start_c ? offset : ptr;
    rd_len_c    = start_c ? len : flen;
    rd_pair_c   = inc1(rd_base_c, rd_len_c);
    ptr_nxt_c   = inc2(rd_base_c, rd_len_c);
    beat_data_c = {msg[rd_base_c], msg[rd_pair_c]};
    len_sat_c   = (len_in > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : len_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      beat          <= '0;
      offset        <= '0;
      ptr           <= '0;
      len           <= '0;
      flen          <= '0;
      pending       <= 1'b0;
      tick_cnt      <= '0;
      host_gnt      <= 1'b0;
      av_chipselect <= 1'b0;
      av_write      <= 1'b0;
      av_address    <= '0;
      av_writedata  <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      for (int i = 0; i < int'(MSG_DEPTH); i++) msg[i] <= '0;
    end else begin
      av_chipselect <= 1'b0;
      av_write      <= 1'b0;
      host_gnt      <= 1'b0;
      frame_done    <= 1'b0;
      tick_cnt      <= tick_c ? '0 : tick_cnt + TW'(1);

      if (decide_c) begin
        state <= pick_c;
        busy  <= (pick_c != IDLE);
        case (pick_c)
          FRAME: begin
            beat          <= 2'd0;
            av_chipselect <= 1'b1;
            av_write      <= 1'b1;
            av_address    <= 2'd0;
            av_writedata  <= beat_data_c;
            ptr           <= ptr_nxt_c;
            flen          <= len;
            offset        <= inc1(offset, len);
            pending       <= 1'b0;
          end
          HOST: begin
            av_chipselect <= 1'b1;
            av_write      <= 1'b1;
            host_gnt      <= 1'b1;
            av_address    <= host_addr;
            av_writedata  <= host_data;
          end
          default: ;
        endcase
      end else begin
        // Mid-frame: frame is atomic, no arbitration
        beat          <= beat + 2'd1;
        av_chipselect <= 1'b1;
        av_write      <= 1'b1;
        av_address    <= beat + 2'd1;
        av_writedata  <= beat_data_c;
        ptr           <= ptr_nxt_c;
        frame_done    <= (beat == 2'd2);
      end

      // A new tick outranks the frame-start clear; repeated ticks coalesce
      if (tick_c && enable && (len != '0)) pending <= 1'b1;

      if (load_valid) msg[load_index] <= load_data;

      if (len_wr) begin
        len    <= len_sat_c;
        offset <= '0;
      end
    end
  end

endmodule

// File: tb/tb_led_scroll_ctrl.sv
// Scoreboard bench for led_scroll_ctrl: expected slave writes are queued as
// stimulus is applied and compared in order as the DUT issues them.
module tb_led_scroll_ctrl;

  localparam int unsigned MSG_DEPTH = 32;
  localparam int unsigned TICK_DIV  = 16;
  localparam int unsigned AW        = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          load_valid = 1'b0;
  logic [AW-1:0] load_index = '0;
  logic [7:0]    load_data = '0;
  logic          len_wr = 1'b0;
  logic [AW:0]   len_in = '0;
  logic          host_req = 1'b0;
  logic [1:0]    host_addr = '0;
  logic [15:0]   host_data = '0;
  logic          host_gnt;
  logic          av_chipselect;
  logic          av_write;
  logic [1:0]    av_address;
  logic [15:0]   av_writedata;
  logic          busy;
  logic          frame_done;

  led_scroll_ctrl #(.MSG_DEPTH(MSG_DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .load_valid(load_valid), .load_index(load_index), .load_data(load_data),
    .len_wr(len_wr), .len_in(len_in),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
    .host_gnt(host_gnt), .av_chipselect(av_chipselect), .av_write(av_write),
    .av_address(av_address), .av_writedata(av_writedata),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int tcnt = 0;
  int wr_cnt = 0;
  int fd_cnt = 0;
  int model_off = 0;
  int model_len = 0;
  logic [7:0]  mdl [MSG_DEPTH];
  logic [21:0] exp_q [$];
  int          starts [$];
  logic [21:0] mon_got;
  logic [21:0] mon_exp;

  // entry: {cs, wr, gnt, frame_done, addr[1:0], data[15:0]}
  function automatic logic [21:0] mk(input logic gnt, input logic fd,
                                     input logic [1:0] a, input logic [15:0] d);
    return {1'b1, 1'b1, gnt, fd, a, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    tcnt <= (reset || tcnt == int'(TICK_DIV) - 1) ? 0 : tcnt + 1;
  end

  // Monitor: every slave-side activity must match the head of the scoreboard
  always @(negedge clk) begin
    mon_got = {av_chipselect, av_write, host_gnt, frame_done, av_address, av_writedata};
    if (av_write) wr_cnt++;
    if (frame_done) fd_cnt++;
    if (|mon_got[21:18]) begin
      if (exp_q.size() == 0) check("unexpected_wr", 32'(mon_got), 32'h0);
      else begin
        mon_exp = exp_q.pop_front();
        check("wr", 32'(mon_got), 32'(mon_exp));
        if (!mon_exp[19] && mon_exp[17:16] == 2'd0) starts.push_back(cyc);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input int i, input logic [7:0] d);
    load_valid = 1'b1; load_index = AW'(i); load_data = d; mdl[i] = d;
    step();
    load_valid = 1'b0;
  endtask

  task automatic set_len(input int n);
    len_wr = 1'b1; len_in = (AW+1)'(n);
    step();
    len_wr = 1'b0;
    model_len = n; model_off = 0;
  endtask

  // digit k = msg[(offset + k) mod len]; beat a carries digits 2a, 2a+1
  task automatic push_frame(input int nbeats);
    for (int a = 0; a < nbeats; a++) begin
      int i0, i1;
      i0 = (model_off + 2*a) % model_len;
      i1 = (model_off + 2*a + 1) % model_len;
      exp_q.push_back(mk(1'b0, a == 3, 2'(a), {mdl[i0], mdl[i1]}));
    end
    model_off = (model_off + 1) % model_len;
  endtask

  task automatic wait_fd(input int target, input int budget);
    int k = 0;
    while (fd_cnt < target && k < budget) begin step(); k++; end
    check("fd_count", 32'(fd_cnt), 32'(target));
  endtask

  task automatic wait_beat(input int a, input int budget);
    int k = 0;
    while (!(av_write && !host_gnt && av_address == 2'(a)) && k < budget) begin step(); k++; end
    check("beat_seen", 32'(av_write && !host_gnt && av_address == 2'(a)), 32'd1);
  endtask

  task automatic align_enable();
    int k = 0;
    while (tcnt != 0 && k < 40) begin step(); k++; end
    enable = 1'b1;
  endtask

  initial begin
    int tgt, w, req_cyc, gnt_cyc, k, g;
    for (int i = 0; i < int'(MSG_DEPTH); i++) mdl[i] = 8'h00;
    step(2);
    reset = 1'b0;
    check("rst_out", 32'({av_chipselect, av_write, host_gnt, frame_done, busy, av_address, av_writedata}), 32'h0);

    // Scroll len=5: two frames, 16 cycles apart
    for (int i = 0; i < 5; i++) load(i, 8'(i + 1));
    set_len(5);
    starts.delete();
    push_frame(4); push_frame(4);
    tgt = fd_cnt + 2;
    enable = 1'b1;
    wait_fd(tgt, 60);
    enable = 1'b0;
    check("t1_nstart", 32'(starts.size()), 32'd2);
    if (starts.size() >= 2) check("t1_period", 32'(starts[1] - starts[0]), 32'd16);

    // len=1 repeats one byte everywhere
    load(0, 8'h3F);
    set_len(1);
    push_frame(4);
    tgt = fd_cnt + 1;
    enable = 1'b1;
    wait_fd(tgt, 40);
    enable = 1'b0;

    // len=0 with enable, and enable=0 with len=5: silence
    set_len(0);
    enable = 1'b1;
    w = wr_cnt;
    step(100);
    check("len0_quiet", 32'(wr_cnt - w), 32'd0);
    enable = 1'b0;
    load(0, 8'h01);
    set_len(5);
    w = wr_cnt;
    step(100);
    check("dis_quiet", 32'(wr_cnt - w), 32'd0);

    // Host request in the cycle pending becomes visible
    starts.delete();
    align_enable();
    k = 0;
    while (tcnt != int'(TICK_DIV) - 1 && k < 40) begin step(); k++; end
    step();
    host_req = 1'b1; host_addr = 2'd2; host_data = 16'hBEEF;
    req_cyc = cyc;
    exp_q.push_back(mk(1'b1, 1'b0, 2'd2, 16'hBEEF));
    push_frame(4);
    gnt_cyc = -100;
    k = 0;
    while (k < 10) begin
      step(); k++;
      if (host_gnt) begin gnt_cyc = cyc; break; end
    end
    host_req = 1'b0;
    check("host_lat", 32'(gnt_cyc - req_cyc), 32'd1);
    tgt = fd_cnt + 1;
    wait_fd(tgt, 20);
    enable = 1'b0;
    check("t3_nstart", 32'(starts.size()), 32'd1);
    if (starts.size() >= 1) check("frame_after_host", 32'(starts[0] - gnt_cyc), 32'd1);

    // Host held from frame beat 1 while ticks keep arriving: no starvation
    push_frame(4);
    align_enable();
    wait_beat(1, 40);
    host_req = 1'b1; host_addr = 2'd1; host_data = 16'hA5A5;
    for (int r = 0; r < 2; r++) begin
      for (int h = 0; h < int'(TICK_DIV) - 4; h++) exp_q.push_back(mk(1'b1, 1'b0, 2'd1, 16'hA5A5));
      push_frame(4);
    end
    k = 0; g = 0;
    while (k < 3 && g < 120) begin
      step(); g++;
      if (frame_done) k++;
    end
    host_req = 1'b0;
    enable = 1'b0;
    check("t4_frames", 32'(k), 32'd3);
    step(3);

    // Length change mid-frame applies from the next frame
    push_frame(4);
    tgt = fd_cnt + 2;
    align_enable();
    wait_beat(1, 40);
    set_len(3);
    push_frame(4);
    wait_fd(tgt, 60);
    enable = 1'b0;

    // Reset at beat 2 abandons the frame and clears everything
    push_frame(3);
    align_enable();
    wait_beat(2, 40);
    reset = 1'b1;
    step();
    check("rst_mid", 32'({av_chipselect, av_write, host_gnt, frame_done, busy, av_address, av_writedata}), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < int'(MSG_DEPTH); i++) mdl[i] = 8'h00;
    model_len = 0; model_off = 0;
    w = wr_cnt;
    step(40);
    check("post_rst_quiet", 32'(wr_cnt - w), 32'd0);
    set_len(4);
    push_frame(4);
    tgt = fd_cnt + 1;
    wait_fd(tgt, 40);
    enable = 1'b0;
    step(5);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
